// File: rtl/sobel_window_gen.sv
// sobel_window_gen
// Producer side of the 3x3 edge-detection window. Turns a raster pixel stream
// into three 72-bit row words (lines r-2, r-1, r) plus the aligned centre pixel.
// Two previous lines live in distributed RAM (combinational read, synchronous write).
// Row word packing: [23:0] = column c-2, [47:24] = column c-1, [71:48] = column c.

module sobel_window_gen #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int COL_W    = 10,
    parameter int ROW_W    = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] in_Pixel,
    input  logic        in_valid,
    input  logic        in_sof,
    output logic [71:0] out_M0,
    output logic [71:0] out_M1,
    output logic [71:0] out_M2,
    output logic [23:0] out_Pixel,
    output logic        out_valid,
    output logic        frame_done,
    output logic        sof_err
);

    // Line-buffer address width; the column counter is never beyond H_ACTIVE-1.
    localparam int AW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_ACTIVE - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_ACTIVE - 1);
    localparam logic [COL_W-1:0] COL_ZERO = {COL_W{1'b0}};
    localparam logic [ROW_W-1:0] ROW_ZERO = {ROW_W{1'b0}};
    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

    typedef enum logic [0:0] {
        ST_WAIT_SOF = 1'b0,
        ST_ACTIVE   = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Raster position of the next expected pixel.
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;

    // Position actually assigned to the pixel presented this cycle (SOF forces 0,0).
    logic [COL_W-1:0] w_col_cur;
    logic [ROW_W-1:0] w_row_cur;
    logic [COL_W-1:0] w_col_next;
    logic [ROW_W-1:0] w_row_next;

    logic w_accept;
    logic w_sof_err;
    logic w_frame_done;
    logic w_win_valid;

    // Line buffers: LB1 = line r-1, LB2 = line r-2. Contents are not reset.
    logic [23:0] r_lb1 [0:H_ACTIVE-1];
    logic [23:0] r_lb2 [0:H_ACTIVE-1];
    logic [AW-1:0] w_lb_addr;
    logic [23:0]   w_lb1_rd;
    logic [23:0]   w_lb2_rd;

    // Window shift registers and registered status outputs.
    logic [71:0] r_m0;
    logic [71:0] r_m1;
    logic [71:0] r_m2;
    logic [23:0] r_pixel;
    logic        r_valid;
    logic        r_frame_done;
    logic        r_sof_err;

    assign w_lb_addr = w_col_cur[AW-1:0];
    assign w_lb1_rd  = r_lb1[w_lb_addr];
    assign w_lb2_rd  = r_lb2[w_lb_addr];

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_WAIT_SOF;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: decide acceptance, the pixel's position and the event flags.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_col_cur    = r_col;
        w_row_cur    = r_row;
        w_sof_err    = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            ST_WAIT_SOF: begin
                if (in_valid && in_sof) begin
                    w_accept     = 1'b1;
                    w_col_cur    = COL_ZERO;
                    w_row_cur    = ROW_ZERO;
                    w_state_next = ST_ACTIVE;
                end else begin
                    w_state_next = ST_WAIT_SOF;
                end
            end
            ST_ACTIVE: begin
                if (in_valid && in_sof) begin
                    // SOF wins over the last-pixel position: restart, stay active.
                    w_accept     = 1'b1;
                    w_col_cur    = COL_ZERO;
                    w_row_cur    = ROW_ZERO;
                    w_sof_err    = (r_col != COL_ZERO) || (r_row != ROW_ZERO);
                    w_state_next = ST_ACTIVE;
                end else if (in_valid) begin
                    w_accept = 1'b1;
                    if ((r_col == COL_LAST) && (r_row == ROW_LAST)) begin
                        w_frame_done = 1'b1;
                        w_state_next = ST_WAIT_SOF;
                    end else begin
                        w_state_next = ST_ACTIVE;
                    end
                end else begin
                    w_state_next = ST_ACTIVE;
                end
            end
            default: begin
                w_state_next = ST_WAIT_SOF;
            end
        endcase
    end

    // Raster advance after the current pixel and the window-valid condition.
    always_comb begin
        w_col_next  = w_col_cur;
        w_row_next  = w_row_cur;
        if (w_col_cur == COL_LAST) begin
            w_col_next = COL_ZERO;
            if (w_row_cur == ROW_LAST) begin
                w_row_next = ROW_ZERO;
            end else begin
                w_row_next = w_row_cur + ROW_ONE;
            end
        end else begin
            w_col_next = w_col_cur + COL_ONE;
            w_row_next = w_row_cur;
        end
        // Windows never straddle a line boundary and need two buffered lines.
        w_win_valid = (w_row_cur >= ROW_TWO) && (w_col_cur >= COL_TWO);
    end

    // Column/row counters move only on an accepted pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= COL_ZERO;
            r_row <= ROW_ZERO;
        end else if (w_accept) begin
            r_col <= w_col_next;
            r_row <= w_row_next;
        end else begin
            r_col <= r_col;
            r_row <= r_row;
        end
    end

    // Line-buffer update: current pixel into LB1, displaced LB1 entry into LB2.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb1[w_lb_addr] <= in_Pixel;
            r_lb2[w_lb_addr] <= w_lb1_rd;
        end
    end

    // Window shift: newest column enters at the top bits, oldest drops off the bottom.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m0    <= 72'h0;
            r_m1    <= 72'h0;
            r_m2    <= 72'h0;
            r_pixel <= 24'h0;
        end else if (w_accept) begin
            r_m0    <= {w_lb2_rd, r_m0[71:24]};
            r_m1    <= {w_lb1_rd, r_m1[71:24]};
            r_m2    <= {in_Pixel, r_m2[71:24]};
            // After the shift, the middle of M1 is the previous newest M1 column.
            r_pixel <= r_m1[71:48];
        end else begin
            r_m0    <= r_m0;
            r_m1    <= r_m1;
            r_m2    <= r_m2;
            r_pixel <= r_pixel;
        end
    end

    // One-cycle status pulses aligned with the window they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_frame_done <= 1'b0;
            r_sof_err    <= 1'b0;
        end else begin
            r_valid      <= w_accept && w_win_valid;
            r_frame_done <= w_frame_done;
            r_sof_err    <= w_sof_err;
        end
    end

    assign out_M0     = r_m0;
    assign out_M1     = r_m1;
    assign out_M2     = r_m2;
    assign out_Pixel  = r_pixel;
    assign out_valid  = r_valid;
    assign frame_done = r_frame_done;
    assign sof_err    = r_sof_err;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Self-checking bench for sobel_window_gen (H_ACTIVE=4, V_ACTIVE=3).
// A frame-image reference model predicts each window from the pixels stored
// at their raster positions; a table drives the first clean frame.

module tb_sobel_window_gen;

    localparam int H = 4;
    localparam int V = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] in_Pixel;
    logic        in_valid;
    logic        in_sof;
    logic [71:0] out_M0;
    logic [71:0] out_M1;
    logic [71:0] out_M2;
    logic [23:0] out_Pixel;
    logic        out_valid;
    logic        frame_done;
    logic        sof_err;

    sobel_window_gen #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .COL_W    (2),
        .ROW_W    (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_Pixel   (in_Pixel),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .out_M0     (out_M0),
        .out_M1     (out_M1),
        .out_M2     (out_M2),
        .out_Pixel  (out_Pixel),
        .out_valid  (out_valid),
        .frame_done (frame_done),
        .sof_err    (sof_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses   = 0;

    // Reference model state
    bit          m_active;
    int          m_r;
    int          m_c;
    bit          m_hold;
    logic [23:0] img [0:V-1][0:H-1];
    logic [71:0] e_m0, e_m1, e_m2;
    logic [23:0] e_pix;

    typedef struct {
        logic        v;
        logic        sof;
        logic [23:0] pix;
        logic        ev;
        logic        ed;
        logic        ee;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] p(input int r, input int c);
        logic [3:0] rr;
        logic [3:0] cc;
        rr = 4'(r);
        cc = 4'(c);
        return {8'h00, 4'h0, rr, 4'h0, cc};
    endfunction

    task automatic model_reset();
        m_active = 1'b0;
        m_r      = 0;
        m_c      = 0;
        m_hold   = 1'b0;
    endtask

    // One clock: predict, drive, clock, compare.
    task automatic step(input logic v, input logic s, input logic [23:0] px);
        bit acc, ev, ed, ee;
        acc = v && (m_active || s);
        ev = 1'b0; ed = 1'b0; ee = 1'b0;
        if (acc) begin
            if (s) begin
                ee = m_active && !(m_r == 0 && m_c == 0);
                m_active = 1'b1;
                m_r = 0;
                m_c = 0;
            end else begin
                ed = (m_r == V - 1) && (m_c == H - 1);
            end
            img[m_r][m_c] = px;
            ev = (m_r >= 2) && (m_c >= 2);
            if (ev) begin
                e_m0  = {img[m_r-2][m_c], img[m_r-2][m_c-1], img[m_r-2][m_c-2]};
                e_m1  = {img[m_r-1][m_c], img[m_r-1][m_c-1], img[m_r-1][m_c-2]};
                e_m2  = {img[m_r][m_c],   img[m_r][m_c-1],   img[m_r][m_c-2]};
                e_pix = img[m_r-1][m_c-1];
            end
            m_hold = ev;
            m_c++;
            if (m_c == H) begin
                m_c = 0;
                m_r++;
                if (m_r == V) begin
                    m_r = 0;
                    m_active = 1'b0;
                end
            end
        end
        in_valid = v;
        in_sof   = s;
        in_Pixel = px;
        @(posedge clk);
        #1;
        chk("out_valid", 72'(out_valid), 72'(ev));
        chk("frame_done", 72'(frame_done), 72'(ed));
        chk("sof_err", 72'(sof_err), 72'(ee));
        if (ev || (!acc && m_hold)) begin
            chk("out_M0", out_M0, e_m0);
            chk("out_M1", out_M1, e_m1);
            chk("out_M2", out_M2, e_m2);
            chk("out_Pixel", 72'(out_Pixel), 72'(e_pix));
        end
        if (out_valid) pulses++;
    endtask

    // Pixels first..last-1 of a frame (sof on index 0), random gaps up to maxgap.
    task automatic frame(input logic [23:0] base, input int maxgap, input int first, input int last);
        for (int i = first; i < last; i++) begin
            int g;
            g = $urandom_range(0, maxgap);
            for (int k = 0; k < g; k++) step(1'b0, 1'b0, 24'($urandom));
            step(1'b1, (i == 0), p(i / H, i % H) + base);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_M0"}, out_M0, 72'h0);
        chk({tag, "_M1"}, out_M1, 72'h0);
        chk({tag, "_M2"}, out_M2, 72'h0);
        chk({tag, "_pix"}, 72'(out_Pixel), 72'h0);
        chk({tag, "_valid"}, 72'(out_valid), 72'h0);
        chk({tag, "_done"}, 72'(frame_done), 72'h0);
        chk({tag, "_err"}, 72'(sof_err), 72'h0);
    endtask

    // Asynchronous reset applied between clock edges.
    task automatic mid_reset();
        in_valid = 1'b0;
        in_sof   = 1'b0;
        rst = 1'b1;
        #1;
        check_zero("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        for (int i = 0; i < 12; i++) begin
            tbl[i].v   = 1'b1;
            tbl[i].sof = (i == 0);
            tbl[i].pix = p(i / H, i % H);
            tbl[i].ev  = (i / H == 2) && (i % H >= 2);
            tbl[i].ed  = (i == 11);
            tbl[i].ee  = 1'b0;
        end

        rst = 1'b1;
        in_valid = 1'b0;
        in_sof = 1'b0;
        in_Pixel = 24'h0;
        model_reset();
        #2;
        check_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Pixels without SOF are ignored.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, p(i / H, i % H));

        // Table-driven clean contiguous frame.
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].v, tbl[i].sof, tbl[i].pix);
            chk("tbl_valid", 72'(out_valid), 72'(tbl[i].ev));
            chk("tbl_done", 72'(frame_done), 72'(tbl[i].ed));
            chk("tbl_err", 72'(sof_err), 72'(tbl[i].ee));
            if (i == 10) begin
                chk("first_M0", out_M0, 72'h000002_000001_000000);
                chk("first_M1", out_M1, 72'h000102_000101_000100);
                chk("first_M2", out_M2, 72'h000202_000201_000200);
                chk("first_pix", 72'(out_Pixel), 72'h000101);
            end
        end
        chk("tbl_pulses", 72'(pulses), 72'd2);

        // Same frame with random gaps.
        pulses = 0;
        frame(24'h0, 3, 0, 12);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 24'($urandom));
        chk("gap_pulses", 72'(pulses), 72'd2);

        // Back-to-back frames; frame 2 offset by 24'h100000.
        frame(24'h0, 1, 0, 12);
        pulses = 0;
        frame(24'h100000, 1, 0, 12);
        chk("b2b_pulses", 72'(pulses), 72'd2);

        // Mid-frame SOF at position (1,2).
        frame(24'h0, 1, 0, 6);
        pulses = 0;
        step(1'b1, 1'b1, p(0, 0) + 24'h200000);
        chk("mid_sof_err", 72'(sof_err), 72'd1);
        frame(24'h200000, 2, 1, 12);
        chk("mid_sof_pulses", 72'(pulses), 72'd2);

        // Reset during row 1, then a clean frame.
        frame(24'h0, 1, 0, 6);
        mid_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 24'($urandom));
        pulses = 0;
        frame(24'h300000, 1, 0, 12);
        chk("post_rst_pulses", 72'(pulses), 72'd2);

        // Randomized stream with occasional stray SOFs.
        for (int n = 0; n < 600; n++) begin
            logic v, s;
            v = ($urandom_range(0, 3) != 0);
            if (!m_active) s = v && ($urandom_range(0, 1) == 1);
            else           s = v && ($urandom_range(0, 29) == 0);
            step(v, s, 24'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sobel_window_gen.md
Name: sobel_window_gen

Overview:
- Producer side of the 3x3 edge-detection window interface. Converts a raster pixel stream into three 72-bit row words (top/mid/bottom, 3 pixels each), plus the aligned centre pixel for bypass.
- Sits between the video input stage and the Sobel/threshold processing stage, and feeds that stage's in_M0/in_M1/in_M2 and in_Pixel inputs.
- Buffers two previous lines internally.

Parameters:
- H_ACTIVE, 640, pixels per line (>=3)
- V_ACTIVE, 480, lines per frame (>=3)
- COL_W, 10, column counter width (2^COL_W >= H_ACTIVE)
- ROW_W, 10, row counter width (2^ROW_W >= V_ACTIVE)

Ports:
- clk  in  1  single clock for all logic
- rst  in  1  asynchronous, active-high reset
- in_Pixel  in  24  input pixel, RGB888
- in_valid  in  1  in_Pixel valid this cycle; accepted unconditionally, no backpressure
- in_sof  in  1  start of frame; qualified by in_valid; marks pixel (0,0)
- out_M0  out  72  top row window (line r-2)
- out_M1  out  72  middle row window (line r-1)
- out_M2  out  72  bottom row window (line r, current)
- out_Pixel  out  24  centre pixel (col c-1, line r-1) = out_M1[47:24]
- out_valid  out  1  window words valid this cycle (1-cycle pulse per window)
- frame_done  out  1  1-cycle pulse: last pixel of frame accepted
- sof_err  out  1  1-cycle pulse: in_sof arrived mid-frame

Behaviour:
- Reset: all outputs 0; FSM = WAIT_SOF; col = 0, row = 0; window registers 0. Line-buffer RAM contents are not reset and are don't-care.
- Packing in each row word: bits [23:0] = oldest/left column (c-2), [47:24] = c-1, [71:48] = newest/right column (c). Unused bits: none. Each row word covers 3 pixels x 24 bits.
- Line buffers:
  - Two buffers, depth H_ACTIVE x 24: LB1 holds line r-1, LB2 holds line r-2.
  - Combinational read, synchronous write (distributed RAM).
  - On an accepted pixel at column c: read LB1[c] and LB2[c], write LB1[c] <= in_Pixel and LB2[c] <= old LB1[c].
- Window shift, on an accepted pixel only:
  - Each row's 3-pixel shift register shifts left-to-oldest.
  - New entries: M2 gets in_Pixel, M1 gets LB1[c], M0 gets LB2[c].
- No shift or write occurs when in_valid = 0. Gaps anywhere, including between lines, are tolerated.
- Latency: pixel (c, r) accepted at cycle t. At t+1 the outputs hold columns c-2..c of lines r-2..r. out_valid = 1 at t+1 iff r >= 2 and c >= 2; otherwise 0. Outputs hold their value between accepts.
- Counters:
  - col increments per accepted pixel and wraps to 0 after H_ACTIVE-1; row increments on that wrap.
  - Windows never span a line boundary: out_valid stays low for c = 0, 1.
- FSM:
  - WAIT_SOF: in_valid && !in_sof → pixel ignored (no write, no shift, no count). in_valid && in_sof → pixel accepted as (0,0); go to ACTIVE.
  - ACTIVE: accepted pixel at (H_ACTIVE-1, V_ACTIVE-1) → frame_done = 1 at t+1, aligned with the final out_valid; go to WAIT_SOF.
  - ACTIVE, in_valid && in_sof at position other than (0,0) → sof_err = 1 at t+1; pixel accepted as (0,0); counters restart; stay ACTIVE.
  - In the mid-frame SOF case, out_valid is suppressed until r >= 2 of the new frame.
- Simultaneous events: in_sof together with the last-pixel position is treated as a mid-frame SOF (sof_err = 1, frame_done = 0).
- Reset mid-frame: immediate return to reset state. The next frame requires in_sof.
- No arithmetic on pixel data; pure data movement.

Test Plan:
- Sim config: H_ACTIVE = 4, V_ACTIVE = 3. Pixel encoding p(r,c) = 24'h00_0r_0c.
- Reset asserted mid-stream → all outputs 0 asynchronously. After release, pixels without in_sof produce no out_valid and no state change.
- Contiguous frame of 12 pixels, in_sof on first:
  - out_valid pulses exactly twice: cycles after p(2,2) and p(2,3).
  - First window: out_M0 = {p(0,2), p(0,1), p(0,0)}, out_M1 = {p(1,2), p(1,1), p(1,0)}, out_M2 = {p(2,2), p(2,1), p(2,0)}, out_Pixel = 24'h000101.
  - frame_done coincides with the second pulse.
- Same frame with random 0–3 cycle in_valid gaps, including between lines → identical windows and pulse count. Outputs are stable during gaps.
- Two back-to-back frames where frame 2 values = frame 1 values + 24'h100000 → frame 2 windows contain only frame 2 pixels, with no stale line-buffer data.
- in_sof at pixel p(1,2) of frame 1 → sof_err pulse. Subsequent windows are built from the new frame only; the first out_valid comes after the new (2,2) pixel.
- Reset asserted during row 1, then a new frame → behaviour identical to a clean first frame.
